// File: rtl/crossbar_rr_scheduler.sv
// Packet-level round-robin scheduler for an N x N crossbar fed by show-ahead input FIFOs.
// Each output arbitrates independently and holds its grant until end-of-packet or a beat-count timeout.
module crossbar_rr_scheduler #(
    parameter int N_PORTS   = 4,
    parameter int SEL_W     = $clog2(N_PORTS),
    parameter int MAX_BEATS = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PORTS-1:0]         i_fifo_empty,
    input  logic [N_PORTS*SEL_W-1:0]   i_head_dest,
    input  logic [N_PORTS-1:0]         i_head_eop,
    output logic [N_PORTS*SEL_W-1:0]   o_sel,
    output logic [N_PORTS-1:0]         o_out_en,
    output logic [N_PORTS-1:0]         o_rdreq,
    output logic [N_PORTS-1:0]         o_out_busy,
    output logic [N_PORTS-1:0]         o_err_timeout
);

    localparam int CNT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [N_PORTS-1:0] ONE_HOT0 = {{(N_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    logic [N_PORTS-1:0] r_lock;
    logic [N_PORTS-1:0] w_lock_set [N_PORTS];
    logic [N_PORTS-1:0] w_lock_clr [N_PORTS];
    logic [N_PORTS-1:0] w_rd_k     [N_PORTS];
    logic [N_PORTS-1:0] w_lock_set_all;
    logic [N_PORTS-1:0] w_lock_clr_all;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_out
            state_t             r_state;
            logic [SEL_W-1:0]   r_sel;
            logic [SEL_W-1:0]   r_ptr;
            logic [CNT_W-1:0]   r_cnt;
            logic               r_err;

            logic [N_PORTS-1:0] w_req;
            logic               w_found;
            logic [SEL_W-1:0]   w_winner;
            logic [SEL_W-1:0]   w_idx;
            logic               w_beat;
            logic               w_eop;
            logic               w_last;
            logic               w_release;
            logic               w_timeout;

            // Locked inputs are already owned by some output, so they never request again mid-packet.
            always_comb begin
                w_req = '0;
                for (int i = 0; i < N_PORTS; i++) begin
                    w_req[i] = !i_fifo_empty[i] &&
                               (i_head_dest[i*SEL_W +: SEL_W] == SEL_W'(gi)) &&
                               !r_lock[i];
                end
            end

            always_comb begin
                w_found  = 1'b0;
                w_winner = r_ptr;
                w_idx    = '0;
                for (int j = 0; j < N_PORTS; j++) begin
                    w_idx = r_ptr + SEL_W'(j);
                    if (!w_found && w_req[w_idx]) begin
                        w_found  = 1'b1;
                        w_winner = w_idx;
                    end
                end
            end

            assign w_beat    = (r_state == ST_BUSY) && !i_fifo_empty[r_sel] && !reset;
            assign w_eop     = i_head_eop[r_sel];
            assign w_last    = (r_cnt == CNT_W'(MAX_BEATS - 1));
            assign w_release = w_beat && (w_eop || w_last);
            assign w_timeout = w_beat && w_last && !w_eop;

            assign w_lock_set[gi] = ((r_state == ST_IDLE) && w_found) ? (ONE_HOT0 << w_winner) : '0;
            assign w_lock_clr[gi] = w_release ? (ONE_HOT0 << r_sel) : '0;
            assign w_rd_k[gi]     = w_beat ? (ONE_HOT0 << r_sel) : '0;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_sel   <= '0;
                    r_ptr   <= '0;
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                end else begin
                    r_err <= w_timeout;
                    case (r_state)
                        ST_IDLE: begin
                            if (w_found) begin
                                r_state <= ST_BUSY;
                                r_sel   <= w_winner;
                                r_cnt   <= '0;
                            end
                        end
                        ST_BUSY: begin
                            // Stalled cycles (empty FIFO) leave the counter untouched.
                            if (w_release) begin
                                r_state <= ST_IDLE;
                                r_ptr   <= r_sel + SEL_W'(1);
                            end else if (w_beat) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end

            assign o_sel[gi*SEL_W +: SEL_W] = r_sel;
            assign o_out_en[gi]             = w_beat;
            assign o_out_busy[gi]           = (r_state == ST_BUSY);
            assign o_err_timeout[gi]        = r_err;
        end
    endgenerate

    always_comb begin
        w_lock_set_all = '0;
        w_lock_clr_all = '0;
        o_rdreq        = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_lock_set_all = w_lock_set_all | w_lock_set[k];
            w_lock_clr_all = w_lock_clr_all | w_lock_clr[k];
            o_rdreq        = o_rdreq | w_rd_k[k];
        end
    end

    // Set and clear never target the same input: only unlocked inputs can win, only locked ones release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock <= '0;
        end else begin
            r_lock <= (r_lock & ~w_lock_clr_all) | w_lock_set_all;
        end
    end

endmodule

// File: tb/tb_crossbar_rr_scheduler.sv
// Directed testbench for crossbar_rr_scheduler: emulates four show-ahead FIFOs and checks
// grants, beats, pops and timeout pulses cycle by cycle against hand-computed tables.
module tb_crossbar_rr_scheduler;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   fifo_empty;
    logic [N*SW-1:0] head_dest;
    logic [N-1:0]   head_eop;
    logic [N*SW-1:0] o_sel;
    logic [N-1:0]   o_out_en;
    logic [N-1:0]   o_rdreq;
    logic [N-1:0]   o_out_busy;
    logic [N-1:0]   o_err_timeout;

    logic [2:0]     mem [N][32];
    int             rd_p [N];
    int             wr_p [N];
    logic [N-1:0]   stall;
    logic [N-1:0]   stall_pend;

    int checks;
    int failures;

    crossbar_rr_scheduler #(.N_PORTS(N), .SEL_W(SW), .MAX_BEATS(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_fifo_empty (fifo_empty),
        .i_head_dest  (head_dest),
        .i_head_eop   (head_eop),
        .o_sel        (o_sel),
        .o_out_en     (o_out_en),
        .o_rdreq      (o_rdreq),
        .o_out_busy   (o_out_busy),
        .o_err_timeout(o_err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            logic [2:0] w;
            logic       ne;
            w  = mem[i][rd_p[i] % 32];
            ne = (rd_p[i] != wr_p[i]);
            fifo_empty[i]          = !ne || stall[i];
            head_dest[i*SW +: SW]  = ne ? w[1:0] : 2'b00;
            head_eop[i]            = ne ? w[2] : 1'b0;
        end
    endtask

    task automatic push_pkt(input int src, input int dst, input int beats);
        for (int b = 0; b < beats; b++) begin
            mem[src][wr_p[src] % 32] = {(b == beats - 1), 2'(dst)};
            wr_p[src]++;
        end
        $display("push: in%0d -> out%0d, %0d beats", src, dst, beats);
        refresh();
        #1;
    endtask

    task automatic tick();
        logic [N-1:0] r;
        r = o_rdreq;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (r[i]) rd_p[i]++;
        stall = stall_pend;
        refresh();
        #1;
        if (!reset) begin
            checks++;
            if ((o_rdreq & fifo_empty) !== '0) begin
                failures++;
                $display("FAIL rdreq_while_empty: rdreq=%b empty=%b required overlap=0000", o_rdreq, fifo_empty);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            rd_p[i] = 0;
            wr_p[i] = 0;
        end
        stall      = '0;
        stall_pend = '0;
        refresh();
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        $display("test_reset");
        checks++;
        if ({o_out_busy, o_out_en, o_rdreq, o_err_timeout} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: busy/en/rd/err=%h required 0000", {o_out_busy, o_out_en, o_rdreq, o_err_timeout});
        end
        checks++;
        if (o_sel !== 8'h00) begin
            failures++;
            $display("FAIL reset_sel: sel=%h required 00", o_sel);
        end
    endtask

    task automatic test_single();
        logic [3:0] exp_en [5] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
        logic [3:0] exp_rd [5] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
        do_reset();
        $display("test_single");
        push_pkt(0, 2, 3);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (o_out_en !== exp_en[c]) begin
                failures++;
                $display("FAIL single_out_en c=%0d got=%b required=%b", c, o_out_en, exp_en[c]);
            end
            checks++;
            if (o_rdreq !== exp_rd[c]) begin
                failures++;
                $display("FAIL single_rdreq c=%0d got=%b required=%b", c, o_rdreq, exp_rd[c]);
            end
            checks++;
            if (o_out_busy !== exp_en[c]) begin
                failures++;
                $display("FAIL single_busy c=%0d got=%b required=%b", c, o_out_busy, exp_en[c]);
            end
            if (c == 1) begin
                checks++;
                if (o_sel[5:4] !== 2'd0) begin
                    failures++;
                    $display("FAIL single_sel2 got=%0d required=0", o_sel[5:4]);
                end
            end
            tick();
        end
        checks++;
        if (rd_p[0] != 3) begin
            failures++;
            $display("FAIL single_pops got=%0d required=3", rd_p[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_en [9] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2};
        logic [3:0] exp_rd [9] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8};
        logic [1:0] exp_s1 [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
        do_reset();
        $display("test_back_to_back");
        push_pkt(0, 1, 2);
        push_pkt(1, 1, 2);
        push_pkt(3, 1, 2);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (o_out_en !== exp_en[c]) begin
                failures++;
                $display("FAIL b2b_out_en c=%0d got=%b required=%b", c, o_out_en, exp_en[c]);
            end
            checks++;
            if (o_rdreq !== exp_rd[c]) begin
                failures++;
                $display("FAIL b2b_rdreq c=%0d got=%b required=%b", c, o_rdreq, exp_rd[c]);
            end
            checks++;
            if (o_sel[3:2] !== exp_s1[c]) begin
                failures++;
                $display("FAIL b2b_sel1 c=%0d got=%0d required=%0d", c, o_sel[3:2], exp_s1[c]);
            end
            tick();
        end
        // pointer must have wrapped back to 0: in0 beats in3
        push_pkt(0, 1, 1);
        push_pkt(3, 1, 1);
        tick();
        checks++;
        if (o_rdreq !== 4'h1 || o_out_en !== 4'h2) begin
            failures++;
            $display("FAIL b2b_ptr_wrap rd=%b en=%b required rd=0001 en=0010", o_rdreq, o_out_en);
        end
        tick();
        tick();
        checks++;
        if (o_rdreq !== 4'h8 || o_sel[3:2] !== 2'd3) begin
            failures++;
            $display("FAIL b2b_second rd=%b sel1=%0d required rd=1000 sel1=3", o_rdreq, o_sel[3:2]);
        end
        tick();
    endtask

    task automatic test_parallel();
        do_reset();
        $display("test_parallel");
        push_pkt(0, 3, 2);
        push_pkt(1, 2, 2);
        push_pkt(2, 1, 2);
        push_pkt(3, 0, 2);
        checks++;
        if (o_out_en !== 4'h0) begin
            failures++;
            $display("FAIL par_arb_cycle en=%b required=0000", o_out_en);
        end
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (o_out_en !== 4'hF || o_rdreq !== 4'hF) begin
                failures++;
                $display("FAIL par_beat c=%0d en=%b rd=%b required en=1111 rd=1111", c, o_out_en, o_rdreq);
            end
            checks++;
            if (o_sel !== 8'h1B) begin
                failures++;
                $display("FAIL par_sel c=%0d got=%h required=1b", c, o_sel);
            end
        end
        tick();
        checks++;
        if (o_out_en !== 4'h0 || o_out_busy !== 4'h0) begin
            failures++;
            $display("FAIL par_release en=%b busy=%b required 0000/0000", o_out_en, o_out_busy);
        end
    endtask

    task automatic test_stall();
        do_reset();
        $display("test_stall");
        push_pkt(2, 0, 3);
        tick();
        checks++;
        if (o_out_en !== 4'h1 || o_rdreq !== 4'h4 || o_sel[1:0] !== 2'd2) begin
            failures++;
            $display("FAIL stall_beat1 en=%b rd=%b sel0=%0d required 0001/0100/2", o_out_en, o_rdreq, o_sel[1:0]);
        end
        stall_pend[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_out_en !== 4'h0 || o_rdreq !== 4'h0 || o_out_busy !== 4'h1) begin
                failures++;
                $display("FAIL stall_hold c=%0d en=%b rd=%b busy=%b required 0000/0000/0001", c, o_out_en, o_rdreq, o_out_busy);
            end
        end
        stall_pend[2] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (o_out_en !== 4'h1 || o_rdreq !== 4'h4) begin
                failures++;
                $display("FAIL stall_resume c=%0d en=%b rd=%b required 0001/0100", c, o_out_en, o_rdreq);
            end
        end
        tick();
        checks++;
        if (o_out_busy !== 4'h0 || o_err_timeout !== 4'h0 || rd_p[2] != 3) begin
            failures++;
            $display("FAIL stall_release busy=%b err=%b pops=%0d required 0000/0000/3", o_out_busy, o_err_timeout, rd_p[2]);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_en  [9] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0};
        logic [3:0] exp_rd  [9] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0};
        logic [3:0] exp_err [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
        do_reset();
        $display("test_timeout");
        push_pkt(1, 3, 6);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (o_out_en !== exp_en[c] || o_out_busy !== exp_en[c]) begin
                failures++;
                $display("FAIL tmo_en_busy c=%0d en=%b busy=%b required=%b", c, o_out_en, o_out_busy, exp_en[c]);
            end
            checks++;
            if (o_rdreq !== exp_rd[c]) begin
                failures++;
                $display("FAIL tmo_rdreq c=%0d got=%b required=%b", c, o_rdreq, exp_rd[c]);
            end
            checks++;
            if (o_err_timeout !== exp_err[c]) begin
                failures++;
                $display("FAIL tmo_err c=%0d got=%b required=%b", c, o_err_timeout, exp_err[c]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        $display("test_reset_mid");
        push_pkt(2, 1, 2);
        tick();
        tick();
        tick();
        checks++;
        if (o_out_busy !== 4'h0) begin
            failures++;
            $display("FAIL rmid_first_done busy=%b required=0000", o_out_busy);
        end
        push_pkt(0, 1, 4);
        tick();
        tick();
        checks++;
        if (o_out_en !== 4'h2 || o_rdreq !== 4'h1) begin
            failures++;
            $display("FAIL rmid_beat2 en=%b rd=%b required 0010/0001", o_out_en, o_rdreq);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (o_rdreq !== 4'h0 || o_out_en !== 4'h0) begin
            failures++;
            $display("FAIL rmid_no_pop_in_reset rd=%b en=%b required 0000/0000", o_rdreq, o_out_en);
        end
        tick();
        checks++;
        if ({o_out_busy, o_out_en, o_rdreq, o_err_timeout} !== 16'h0 || o_sel !== 8'h00) begin
            failures++;
            $display("FAIL rmid_after_reset busy/en/rd/err=%h sel=%h required 0000/00", {o_out_busy, o_out_en, o_rdreq, o_err_timeout}, o_sel);
        end
        reset = 1'b0;
        push_pkt(3, 1, 1);
        tick();
        checks++;
        if (o_sel[3:2] !== 2'd0 || o_rdreq !== 4'h1 || o_out_en !== 4'h2) begin
            failures++;
            $display("FAIL rmid_ptr_restart sel1=%0d rd=%b en=%b required 0/0001/0010", o_sel[3:2], o_rdreq, o_out_en);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        stall      = '0;
        stall_pend = '0;
        for (int i = 0; i < N; i++) begin
            rd_p[i] = 0;
            wr_p[i] = 0;
        end
        refresh();
        test_reset();
        test_single();
        test_back_to_back();
        test_parallel();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
